// File: rtl/sr_bank_arbiter.sv
// rtl/sr_bank_arbiter.sv - round-robin arbiter driving a bank of set/reset storage bits
// One command wins per cycle, so no bit ever sees set and reset together.
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      gnt,
  output logic [NBITS-1:0]     q,
  output logic [NBITS-1:0]     qbar,
  output logic [7:0]           conflict_cnt
);

  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTRW-1:0]  ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NBITS-1:0] bank_q, bank_d;
  logic [7:0]       cnt_q, cnt_d;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [PTRW-1:0]  win;
  logic [IDXW-1:0]  idx_w;
  logic             collide;
  int               k;

  // A requester just granted is masked for one cycle so a held req is not served twice.
  always_comb begin
    elig  = req & ~gnt_q;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int n = 0; n < NREQ; n++) begin
      k = int'(ptr_q) + n;
      if (k >= NREQ) k = k - NREQ;
      if (!found && elig[k]) begin
        found = 1'b1;
        win   = PTRW'(k);
      end
    end
    idx_w = idx[int'(win)*IDXW +: IDXW];
  end

  always_comb begin
    collide = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (elig[i] && elig[j] && (op[i] != op[j]) &&
            (idx[i*IDXW +: IDXW] == idx[j*IDXW +: IDXW])) begin
          collide = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ptr_d  = ptr_q;
    gnt_d  = '0;
    bank_d = bank_q;
    cnt_d  = cnt_q;
    if (rst) begin
      ptr_d  = '0;
      bank_d = '0;
      cnt_d  = '0;
    end else begin
      if (collide && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
      // clr_all wins over a pending winner; the request stays pending and ptr holds.
      if (clr_all) begin
        bank_d = '0;
      end else if (found) begin
        gnt_d         = NREQ'(1) << win;
        bank_d[idx_w] = op[win];
        if (int'(win) == NREQ - 1) ptr_d = '0;
        else                       ptr_d = win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    ptr_q  <= ptr_d;
    gnt_q  <= gnt_d;
    bank_q <= bank_d;
    cnt_q  <= cnt_d;
  end

  assign gnt          = gnt_q;
  assign q            = bank_q;
  assign qbar         = ~bank_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb/tb_sr_bank_arbiter.sv - self-checking bench for sr_bank_arbiter
// A reference model predicts every cycle into a scoreboard; tasks add directed checks.
module tb_sr_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [3:0]  op  = '0;
  logic [11:0] idx = '0;
  logic        clr_all = 1'b0;
  logic [3:0]  gnt;
  logic [7:0]  q, qbar, conflict_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0] g;
    logic [7:0] b;
    logic [7:0] c;
  } exp_t;
  exp_t sb[$];

  logic [3:0] m_gnt = '0;
  logic [7:0] m_q   = '0;
  int         m_ptr = 0;
  int         m_cnt = 0;

  sr_bank_arbiter #(.NREQ(4), .NBITS(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .idx(idx), .clr_all(clr_all),
    .gnt(gnt), .q(q), .qbar(qbar), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    exp_t e;
    logic [3:0] el;
    int w;
    logic col;
    el = req & ~m_gnt;
    w = -1;
    for (int n = 0; n < 4; n++) begin
      if (w < 0 && el[(m_ptr + n) % 4]) w = (m_ptr + n) % 4;
    end
    col = 1'b0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (i != j && el[i] && el[j] && op[i] != op[j] && idx[i*3 +: 3] == idx[j*3 +: 3]) col = 1'b1;
    if (rst) begin
      m_gnt = '0; m_q = '0; m_ptr = 0; m_cnt = 0;
    end else begin
      if (col && m_cnt < 255) m_cnt = m_cnt + 1;
      if (clr_all) begin
        m_q = '0; m_gnt = '0;
      end else if (w >= 0) begin
        m_gnt = 4'b0001 << w;
        m_q[idx[w*3 +: 3]] = op[w];
        m_ptr = (w + 1) % 4;
      end else begin
        m_gnt = '0;
      end
    end
    e.g = m_gnt; e.b = m_q; e.c = 8'(m_cnt);
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_tests += 4;
      if (gnt !== e.g) begin $display("FAIL sb_gnt: got %b want %b", gnt, e.g); n_fail++; end
      if (q !== e.b) begin $display("FAIL sb_q: got %h want %h", q, e.b); n_fail++; end
      if (qbar !== ~e.b) begin $display("FAIL sb_qbar: got %h want %h", qbar, ~e.b); n_fail++; end
      if (conflict_cnt !== e.c) begin $display("FAIL sb_cnt: got %0d want %0d", conflict_cnt, e.c); n_fail++; end
    end
  end

  task automatic do_reset();
    req = '0; clr_all = 1'b0; rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req = 4'($urandom); op = 4'($urandom); idx = 12'($urandom); clr_all = 1'($urandom);
      cyc();
    end
    n_tests += 4;
    if (q !== 8'h00) begin $display("FAIL reset_q: got %h want 00", q); n_fail++; end
    if (qbar !== 8'hFF) begin $display("FAIL reset_qbar: got %h want ff", qbar); n_fail++; end
    if (gnt !== 4'b0000) begin $display("FAIL reset_gnt: got %b want 0000", gnt); n_fail++; end
    if (conflict_cnt !== 8'd0) begin $display("FAIL reset_cnt: got %0d want 0", conflict_cnt); n_fail++; end
    rst = 1'b0; clr_all = 1'b0;
    req = 4'b0110; op = 4'b0110; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    cyc();
    n_tests++;
    if (gnt !== 4'b0010) begin $display("FAIL reset_first_gnt: got %b want 0010", gnt); n_fail++; end
    req = '0;
    cyc();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = 12'd5;
    cyc();
    n_tests += 2;
    if (gnt !== 4'b0001) begin $display("FAIL single_set_gnt: got %b want 0001", gnt); n_fail++; end
    if (q !== 8'h20) begin $display("FAIL single_set_q: got %h want 20", q); n_fail++; end
    op = 4'b0000;
    cyc();
    n_tests += 2;
    if (gnt !== 4'b0000) begin $display("FAIL single_mask_gnt: got %b want 0000", gnt); n_fail++; end
    if (q !== 8'h20) begin $display("FAIL single_mask_q: got %h want 20", q); n_fail++; end
    cyc();
    n_tests += 3;
    if (gnt !== 4'b0001) begin $display("FAIL single_rst_gnt: got %b want 0001", gnt); n_fail++; end
    if (q !== 8'h00) begin $display("FAIL single_rst_q: got %h want 00", q); n_fail++; end
    if (qbar !== 8'hFF) begin $display("FAIL single_rst_qbar: got %h want ff", qbar); n_fail++; end
    req = '0;
    cyc();
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int c = 0; c < 8; c++) begin
      cyc();
      want = 4'b0001 << (c % 4);
      n_tests++;
      if (gnt !== want) begin $display("FAIL rr_gnt cycle %0d: got %b want %b", c, gnt, want); n_fail++; end
      if (c == 3) begin
        n_tests++;
        if (q !== 8'h0F) begin $display("FAIL rr_q: got %h want 0f", q); n_fail++; end
      end
    end
    req = '0;
    cyc();
  endtask

  task automatic test_collision();
    do_reset();
    req = 4'b0110; op = 4'b0010; idx = {3'd0, 3'd2, 3'd2, 3'd0};
    cyc();
    n_tests += 3;
    if (gnt !== 4'b0010) begin $display("FAIL coll_gnt1: got %b want 0010", gnt); n_fail++; end
    if (q[2] !== 1'b1) begin $display("FAIL coll_q1: got %b want 1", q[2]); n_fail++; end
    if (conflict_cnt !== 8'd1) begin $display("FAIL coll_cnt1: got %0d want 1", conflict_cnt); n_fail++; end
    cyc();
    n_tests += 3;
    if (gnt !== 4'b0100) begin $display("FAIL coll_gnt2: got %b want 0100", gnt); n_fail++; end
    if (q[2] !== 1'b0) begin $display("FAIL coll_q2: got %b want 0", q[2]); n_fail++; end
    if (conflict_cnt !== 8'd1) begin $display("FAIL coll_cnt2: got %0d want 1", conflict_cnt); n_fail++; end
    req = '0;
    cyc();
  endtask

  task automatic test_saturation();
    do_reset();
    req = 4'b1111; op = 4'b0101; idx = {3'd7, 3'd7, 3'd7, 3'd7};
    for (int c = 1; c <= 300; c++) begin
      cyc();
      if (c == 254) begin
        n_tests++;
        if (conflict_cnt !== 8'd254) begin $display("FAIL sat_254: got %0d want 254", conflict_cnt); n_fail++; end
      end
    end
    n_tests++;
    if (conflict_cnt !== 8'd255) begin $display("FAIL sat_300: got %0d want 255", conflict_cnt); n_fail++; end
    req = '0;
    cyc();
  endtask

  task automatic test_clr_all();
    do_reset();
    for (int b = 0; b < 8; b++) begin
      req = 4'b0001 << (b % 4);
      op = 4'b1111;
      idx[(b % 4)*3 +: 3] = 3'(b);
      cyc();
    end
    req = '0;
    cyc();
    n_tests++;
    if (q !== 8'hFF) begin $display("FAIL clr_pre_q: got %h want ff", q); n_fail++; end
    req = 4'b1000; op = 4'b1000; idx[9 +: 3] = 3'd6; clr_all = 1'b1;
    cyc();
    n_tests += 3;
    if (q !== 8'h00) begin $display("FAIL clr_q: got %h want 00", q); n_fail++; end
    if (qbar !== 8'hFF) begin $display("FAIL clr_qbar: got %h want ff", qbar); n_fail++; end
    if (gnt !== 4'b0000) begin $display("FAIL clr_gnt: got %b want 0000", gnt); n_fail++; end
    clr_all = 1'b0;
    cyc();
    n_tests += 2;
    if (gnt !== 4'b1000) begin $display("FAIL clr_after_gnt: got %b want 1000", gnt); n_fail++; end
    if (q !== 8'h40) begin $display("FAIL clr_after_q: got %h want 40", q); n_fail++; end
    req = '0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_collision();
    test_saturation();
    test_clr_all();
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
# sr_bank_arbiter

Round-robin arbiter and controller for a bank of clocked set/reset storage bits. Multiple requesters issue set or reset commands addressed to one bit of the bank. The block grants one command per cycle and applies it to the bank's q/qbar pair. Because only one command wins each cycle, the forbidden S=R=1 condition can never reach a bit. Same-cycle opposite-op collisions on one bit are counted for debug.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- NBITS, 8: number of SR bits in the bank (power of two, 2..64)
- IDXW, 3: bit-index width, equal to log2(NBITS)

Ports:
- clk  input  1  rising-edge clock; the only clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request valid, one per requester
- op  input  NREQ  command per requester: 1 = set, 0 = reset
- idx  input  NREQ*IDXW  target bit index; requester k uses idx[k*IDXW +: IDXW]
- clr_all  input  1  force every bit to reset; overrides requests
- gnt  output  NREQ  registered one-hot grant pulse
- q  output  NBITS  bank state
- qbar  output  NBITS  always ~q
- conflict_cnt  output  8  saturating collision counter

## Operation
- Reset (rst=1 at an edge) sets q=0, qbar=all ones, gnt=0, conflict_cnt=0 and round-robin pointer ptr=0. Reset overrides clr_all and all requests.
- Eligible requester k: req[k]=1 and gnt[k]=0 in the current cycle. The current-grant mask stops a requester that holds req for one cycle after its grant from being double-served.
- Arbitration: scan requesters starting at ptr, upward with wrap-around, and choose the first eligible one (w). Purely combinational from current inputs and state.
- On the edge after a cycle with winner w:
  - gnt = one-hot(w).
  - q[idx_w] = op[w] and qbar[idx_w] = ~op[w]; all other bits hold.
  - ptr = (w+1) mod NREQ.
- No eligible requester: gnt=0, bank holds and ptr holds.
- clr_all=1 with rst=0:
  - Next edge sets q=0, qbar=all ones and gnt=0.
  - ptr holds and no request is consumed.
  - Pending requesters stay eligible and compete again once clr_all drops.
- Collision: a cycle where at least two eligible requesters target the same idx with different op is one collision.
  - conflict_cnt increments by 1 at the next edge and saturates at 255.
  - Counting happens regardless of which requester wins and regardless of clr_all.
  - Same-idx, same-op requests are not collisions.
- Handshake: a requester holds req, op and idx stable until it sees gnt[k]=1. It may keep req high after that only to issue a new command, which is served on a later rotation.
- Out-of-range idx cannot occur, because IDXW exactly covers NBITS.
- Invariants:
  - qbar == ~q in every cycle.
  - gnt has at most one bit set.
  - No bit ever receives set and reset at the same edge.

## Timing
- Request to grant: 1 cycle. Request sampled in cycle t gives gnt and the q/qbar update at edge t+1; both are visible in the same cycle.
- Throughput: one command per cycle when any requester is eligible.
- Fairness: a continuously requesting requester is granted within NREQ cycles, absent clr_all.
- gnt is a single-cycle pulse per command.
- Reset or clr_all asserted mid-stream takes effect at the next edge. Reset also clears ptr and conflict_cnt; clr_all clears neither.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use NREQ=4, NBITS=8.
- Reset: apply rst for 2 cycles with random requests -> q=8'h00, qbar=8'hFF, gnt=0, conflict_cnt=0; first grant after release goes to the lowest eligible index at or above 0.
- Single set then reset: req0 op=1 idx=5 -> next cycle gnt=4'b0001, q=8'h20; then req0 op=0 idx=5 -> q=8'h00, qbar=8'hFF.
- Round robin: all four req held high for 8 cycles with distinct idx 0..3, op=1 -> gnt sequence 0001,0010,0100,1000,0001,...; q=8'h0F after the first four grants.
- Collision: req1 op=1 idx=2 and req2 op=0 idx=2 in the same cycle from ptr=0 -> gnt=4'b0010, q[2]=1, conflict_cnt=1; next cycle req2 wins, q[2]=0, and conflict_cnt stays 1 because req1 is masked.
- Saturation: force the same opposite-op collision for 300 consecutive cycles -> conflict_cnt stops at 255.
- clr_all mid-stream: q=8'hFF, req3 pending, clr_all pulsed for 1 cycle -> q=8'h00, gnt=0, ptr unchanged; req3 is granted the following cycle.
